// File: rtl/int_controller.sv
// int_controller: interrupt/exception controller for the 16-bit pipeline.
// It takes edge-triggered hardware sources, each with a mask bit, a fixed
// priority and a pending latch. It also handles synchronous soft traps and
// ERET.
//
// Ports:
//   intci_clk, intci_rst    clock, asynchronous active-high reset
//   intci_src_req           asynchronous request levels; a rising edge asks for service
//   intci_mask_wr/_data     mask register write (1 = source enabled)
//   intci_int_enable/_disable  one-cycle pulses that set/clear the global enable
//   intci_soft_int/_id      soft trap request and cause (ERET_ID = return)
//   intci_epc, intci_in_bds, intci_is_branch  interrupt-point PC and its flags
//   intci_stall             blocks hardware interrupts while high
//   intco_set_pc/_target_pc PC redirect pulse and target
//   intco_epc, intco_ecause saved return address and trap cause
//   intco_handling, intco_int_en  handler-active flag, effective enable
//   intco_pending, intco_ack      pending latches, taken-source pulse
module int_controller #(
  parameter int unsigned        NUM_SRC       = 4,
  parameter int unsigned        EPC_W         = 16,
  parameter int unsigned        CAUSE_W       = 4,
  parameter logic [EPC_W-1:0]   VEC_ADDR      = EPC_W'(16'h0004),
  parameter int unsigned        HW_CAUSE_BASE = 8,
  parameter logic [CAUSE_W-1:0] ERET_ID       = '1
) (
  input  logic               intci_clk,
  input  logic               intci_rst,
  input  logic [NUM_SRC-1:0] intci_src_req,
  input  logic               intci_mask_wr,
  input  logic [NUM_SRC-1:0] intci_mask_data,
  input  logic               intci_int_enable,
  input  logic               intci_int_disable,
  input  logic               intci_soft_int,
  input  logic [CAUSE_W-1:0] intci_soft_id,
  input  logic [EPC_W-1:0]   intci_epc,
  input  logic               intci_in_bds,
  input  logic               intci_is_branch,
  input  logic               intci_stall,
  output logic               intco_set_pc,
  output logic [EPC_W-1:0]   intco_target_pc,
  output logic [EPC_W-1:0]   intco_epc,
  output logic [CAUSE_W-1:0] intco_ecause,
  output logic               intco_handling,
  output logic               intco_int_en,
  output logic [NUM_SRC-1:0] intco_pending,
  output logic [NUM_SRC-1:0] intco_ack
);

  localparam logic [CAUSE_W-1:0] HW_BASE = CAUSE_W'(HW_CAUSE_BASE);

  logic [NUM_SRC-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_SRC-1:0] mask_q, pending_q, ack_q;
  logic               global_en_q, handling_q, set_pc_q;
  logic [EPC_W-1:0]   target_q, epc_q;
  logic [CAUSE_W-1:0] ecause_q;

  logic [NUM_SRC-1:0] edge_det, eligible, hw_sel;
  logic [CAUSE_W-1:0] hw_idx;
  logic               hw_found, hw_take, int_en;
  logic [EPC_W-1:0]   hw_epc;

  assign edge_det = sync2_q & ~sync3_q;
  assign eligible = pending_q & mask_q;
  assign int_en   = global_en_q & ~handling_q;

  // Fixed priority: lowest eligible index wins. hw_sel is one-hot.
  always_comb begin
    hw_sel   = '0;
    hw_idx   = '0;
    hw_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && !hw_found) begin
        hw_found  = 1'b1;
        hw_sel[i] = 1'b1;
        hw_idx    = CAUSE_W'(i);
      end
    end
    hw_take = int_en && !intci_stall && hw_found;
  end

  // Return address for a hardware interrupt.
  // A delay-slot instruction restarts at its branch (PC-1).
  // A branch itself restarts at its own PC.
  // Otherwise restart at the next instruction.
  always_comb begin
    if (intci_in_bds)         hw_epc = intci_epc - EPC_W'(1);
    else if (intci_is_branch) hw_epc = intci_epc;
    else                      hw_epc = intci_epc + EPC_W'(1);
  end

  always_ff @(posedge intci_clk or posedge intci_rst) begin
    if (intci_rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      mask_q      <= '1;
      pending_q   <= '0;
      ack_q       <= '0;
      global_en_q <= 1'b0;
      handling_q  <= 1'b0;
      set_pc_q    <= 1'b0;
      target_q    <= '0;
      epc_q       <= '0;
      ecause_q    <= '0;
    end else begin
      sync1_q <= intci_src_req;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;

      if (intci_mask_wr) mask_q <= intci_mask_data;

      if (intci_int_disable)     global_en_q <= 1'b0;
      else if (intci_int_enable) global_en_q <= 1'b1;

      set_pc_q  <= 1'b0;
      ack_q     <= '0;
      pending_q <= pending_q | edge_det;

      if (intci_soft_int && intci_soft_id == ERET_ID) begin
        if (handling_q) begin
          set_pc_q   <= 1'b1;
          target_q   <= epc_q;
          ecause_q   <= '0;
          handling_q <= 1'b0;
        end
      end else if (intci_soft_int) begin
        set_pc_q   <= 1'b1;
        target_q   <= VEC_ADDR;
        epc_q      <= intci_epc + EPC_W'(1);
        ecause_q   <= intci_soft_id;
        handling_q <= 1'b1;
      end else if (hw_take) begin
        set_pc_q   <= 1'b1;
        target_q   <= VEC_ADDR;
        epc_q      <= hw_epc;
        ecause_q   <= HW_BASE + hw_idx;
        handling_q <= 1'b1;
        ack_q      <= hw_sel;
        // A fresh edge in the clearing cycle re-arms the latch.
        pending_q  <= (pending_q & ~hw_sel) | edge_det;
      end
    end
  end

  assign intco_set_pc    = set_pc_q;
  assign intco_target_pc = target_q;
  assign intco_epc       = epc_q;
  assign intco_ecause    = ecause_q;
  assign intco_handling  = handling_q;
  assign intco_int_en    = int_en;
  assign intco_pending   = pending_q;
  assign intco_ack       = ack_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed testbench for int_controller with hand-computed expected values.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_req = '0;
  logic        mask_wr = 1'b0;
  logic [3:0]  mask_data = '0;
  logic        int_enable = 1'b0;
  logic        int_disable = 1'b0;
  logic        soft_int = 1'b0;
  logic [3:0]  soft_id = '0;
  logic [15:0] epc_in = '0;
  logic        in_bds = 1'b0;
  logic        is_branch = 1'b0;
  logic        stall = 1'b0;

  logic        set_pc;
  logic [15:0] target_pc;
  logic [15:0] epc;
  logic [3:0]  ecause;
  logic        handling;
  logic        int_en;
  logic [3:0]  pending;
  logic [3:0]  ack;

  int checks = 0;
  int failures = 0;

  int_controller #(
    .NUM_SRC(4),
    .EPC_W(16),
    .CAUSE_W(4),
    .VEC_ADDR(16'h0004),
    .HW_CAUSE_BASE(8),
    .ERET_ID(4'hF)
  ) dut (
    .intci_clk(clk),
    .intci_rst(rst),
    .intci_src_req(src_req),
    .intci_mask_wr(mask_wr),
    .intci_mask_data(mask_data),
    .intci_int_enable(int_enable),
    .intci_int_disable(int_disable),
    .intci_soft_int(soft_int),
    .intci_soft_id(soft_id),
    .intci_epc(epc_in),
    .intci_in_bds(in_bds),
    .intci_is_branch(is_branch),
    .intci_stall(stall),
    .intco_set_pc(set_pc),
    .intco_target_pc(target_pc),
    .intco_epc(epc),
    .intco_ecause(ecause),
    .intco_handling(handling),
    .intco_int_en(int_en),
    .intco_pending(pending),
    .intco_ack(ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    steps(2);
    check("rst_set_pc", 32'(set_pc), 0);
    check("rst_target", 32'(target_pc), 0);
    check("rst_epc", 32'(epc), 0);
    check("rst_handling", 32'(handling), 0);
    check("rst_int_en", 32'(int_en), 0);
    check("rst_pending", 32'(pending), 0);
    rst = 1'b0;
    step();

    // Enable, then a single edge on source 2
    int_enable = 1'b1;
    step();
    int_enable = 1'b0;
    check("en_int_en", 32'(int_en), 1);
    src_req = 4'b0100;
    epc_in = 16'h0010;
    steps(3);
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_no_setpc_yet", 32'(set_pc), 0);
    step();
    check("t1_set_pc", 32'(set_pc), 1);
    check("t1_target", 32'(target_pc), 32'h0004);
    check("t1_epc", 32'(epc), 32'h0011);
    check("t1_ecause", 32'(ecause), 10);
    check("t1_ack", 32'(ack), 32'h4);
    check("t1_handling", 32'(handling), 1);
    check("t1_int_en", 32'(int_en), 0);
    check("t1_pending_clr", 32'(pending), 0);
    step();
    check("t1_pulse_end", 32'(set_pc), 0);
    check("t1_ack_end", 32'(ack), 0);

    // Sources 1 and 3 together while handling; ERET; priority order
    src_req = 4'b1110;
    steps(4);
    check("t2_pending", 32'(pending), 32'hA);
    check("t2_blocked", 32'(set_pc), 0);
    soft_int = 1'b1; soft_id = 4'hF;
    step();
    soft_int = 1'b0; soft_id = 4'h0;
    epc_in = 16'h0030;
    check("t2_eret_pc", 32'(set_pc), 1);
    check("t2_eret_target", 32'(target_pc), 32'h0011);
    check("t2_eret_handling", 32'(handling), 0);
    check("t2_eret_ecause", 32'(ecause), 0);
    step();
    check("t2_src1_set_pc", 32'(set_pc), 1);
    check("t2_src1_ecause", 32'(ecause), 9);
    check("t2_src1_ack", 32'(ack), 32'h2);
    check("t2_src1_epc", 32'(epc), 32'h0031);
    check("t2_src1_pending", 32'(pending), 32'h8);
    step();
    soft_int = 1'b1; soft_id = 4'hF;
    step();
    soft_int = 1'b0;
    check("t2_eret2_target", 32'(target_pc), 32'h0031);
    step();
    check("t2_src3_ecause", 32'(ecause), 11);
    check("t2_src3_ack", 32'(ack), 32'h8);
    soft_int = 1'b1;
    step();
    soft_int = 1'b0;
    check("t2_eret3_handling", 32'(handling), 0);

    // Soft trap and hardware source 0 in the same cycle: soft wins
    src_req = 4'b1111;
    steps(3);
    check("t3_pending0", 32'(pending), 32'h1);
    soft_int = 1'b1; soft_id = 4'h3; epc_in = 16'h0020;
    step();
    soft_int = 1'b0;
    check("t3_set_pc", 32'(set_pc), 1);
    check("t3_ecause", 32'(ecause), 3);
    check("t3_epc", 32'(epc), 32'h0021);
    check("t3_target", 32'(target_pc), 32'h0004);
    check("t3_no_ack", 32'(ack), 0);
    check("t3_still_pending", 32'(pending), 32'h1);
    step();
    soft_int = 1'b1; soft_id = 4'hF;
    step();
    soft_int = 1'b0;
    epc_in = 16'h0050;
    check("t3_eret_target", 32'(target_pc), 32'h0021);
    step();
    check("t3_src0_ecause", 32'(ecause), 8);
    check("t3_src0_epc", 32'(epc), 32'h0051);
    check("t3_src0_ack", 32'(ack), 32'h1);
    soft_int = 1'b1;
    step();
    soft_int = 1'b0;

    // Delay-slot and branch EPC adjustment (with wrap below zero)
    src_req = 4'b0000;
    steps(3);
    src_req = 4'b0001; epc_in = 16'h0000; in_bds = 1'b1;
    steps(4);
    check("t4_bds_epc", 32'(epc), 32'hFFFF);
    check("t4_bds_set_pc", 32'(set_pc), 1);
    in_bds = 1'b0;
    soft_int = 1'b1;
    step();
    soft_int = 1'b0;
    check("t4_bds_eret_target", 32'(target_pc), 32'hFFFF);
    src_req = 4'b0000;
    steps(3);
    src_req = 4'b0001; epc_in = 16'h0040; is_branch = 1'b1;
    steps(4);
    check("t4_branch_epc", 32'(epc), 32'h0040);
    is_branch = 1'b0;
    soft_int = 1'b1;
    step();
    soft_int = 1'b0;

    // Masking: edge latches but is not taken until unmasked
    mask_wr = 1'b1; mask_data = 4'b1110;
    step();
    mask_wr = 1'b0;
    src_req = 4'b0000;
    steps(3);
    src_req = 4'b0001;
    steps(3);
    check("t5_masked_pending", 32'(pending), 32'h1);
    steps(2);
    check("t5_masked_no_trap", 32'(set_pc), 0);
    check("t5_masked_handling", 32'(handling), 0);
    mask_wr = 1'b1; mask_data = 4'b1111;
    step();
    mask_wr = 1'b0;
    check("t5_unmask_same_cycle", 32'(set_pc), 0);
    step();
    check("t5_unmask_taken", 32'(set_pc), 1);
    check("t5_unmask_ecause", 32'(ecause), 8);
    soft_int = 1'b1;
    step();
    soft_int = 1'b0;

    // Stall holds off hardware interrupts
    stall = 1'b1;
    src_req = 4'b0000;
    steps(3);
    src_req = 4'b0001;
    steps(6);
    check("t5_stall_no_trap", 32'(set_pc), 0);
    check("t5_stall_pending", 32'(pending), 32'h1);
    stall = 1'b0;
    step();
    check("t5_unstall_taken", 32'(set_pc), 1);
    check("t5_unstall_ack", 32'(ack), 32'h1);
    soft_int = 1'b1;
    step();
    soft_int = 1'b0;

    // Enable and disable together: disable wins
    int_enable = 1'b1; int_disable = 1'b1;
    step();
    int_enable = 1'b0; int_disable = 1'b0;
    check("t6_en_dis_int_en", 32'(int_en), 0);

    // ERET with no active handler is ignored
    soft_int = 1'b1; soft_id = 4'hF;
    step();
    soft_int = 1'b0;
    check("t6_eret_idle_no_pc", 32'(set_pc), 0);

    // Reset in the middle of a trap
    src_req = 4'b0000;
    int_enable = 1'b1;
    steps(3);
    int_enable = 1'b0;
    soft_int = 1'b1; soft_id = 4'h5; epc_in = 16'h0077;
    step();
    soft_int = 1'b0;
    check("t6_soft_handling", 32'(handling), 1);
    src_req = 4'b0010;
    steps(3);
    check("t6_pend_before_rst", 32'(pending), 32'h2);
    rst = 1'b1;
    #1;
    check("t6_rst_set_pc", 32'(set_pc), 0);
    check("t6_rst_target", 32'(target_pc), 0);
    check("t6_rst_epc", 32'(epc), 0);
    check("t6_rst_ecause", 32'(ecause), 0);
    check("t6_rst_handling", 32'(handling), 0);
    check("t6_rst_int_en", 32'(int_en), 0);
    check("t6_rst_pending", 32'(pending), 0);
    check("t6_rst_ack", 32'(ack), 0);
    src_req = 4'b0000;
    steps(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
